// File: rtl/program_counter_stack.sv
// Program counter with tri-state bus output, jump/increment, and a hardware return-address stack.
// Optional macro PC_HALT_EN: halts on increment at all-ones instead of wrapping.
module program_counter_stack #(
    parameter int unsigned BUS_W       = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    inout  wire  [BUS_W-1:0]                     bus,
    input  logic                                 co,
    input  logic                                 ce,
    input  logic                                 jmp,
    input  logic                                 call,
    input  logic                                 ret,
    output logic [ADDR_W-1:0]                    pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
    output logic                                 stack_full,
    output logic                                 stack_empty,
`ifdef PC_HALT_EN
    output logic                                 halted,
`endif
    output logic                                 stk_err
);

    localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SpW-1:0] SpFull = SpW'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SpW-1:0]    sp_q, sp_d;
    logic              err_q, err_d;
    logic              push;
    logic [SpW-1:0]    sp_m1;
    logic [ADDR_W-1:0] bus_addr;
    logic [BUS_W-1:0]  bus_out;
    logic              halt_q;
    logic              full, empty;

    // Contents are deliberately not reset; sp alone defines validity.
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    assign full     = (sp_q == SpFull);
    assign empty    = (sp_q == '0);
    assign sp_m1    = sp_q - SpW'(1);
    assign bus_addr = bus[ADDR_W-1:0];
    assign bus_out  = BUS_W'(pc_q);
    assign bus      = co ? bus_out : {BUS_W{1'bz}};

`ifdef PC_HALT_EN
    logic halt_d;
    always_ff @(posedge clk) begin
        if (rst) halt_q <= 1'b0;
        else     halt_q <= halt_d;
    end
    assign halted = halt_q;
`else
    assign halt_q = 1'b0;
`endif

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
`ifdef PC_HALT_EN
        halt_d = halt_q;
`endif
        if (!halt_q) begin
            if (call) begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp_q + SpW'(1);
                    pc_d = bus_addr;
                end
            end else if (ret) begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    sp_d = sp_m1;
                    pc_d = stack_q[sp_m1[IdxW-1:0]];
                end
            end else if (jmp) begin
                pc_d = bus_addr;
            end else if (ce) begin
`ifdef PC_HALT_EN
                if (&pc_q) halt_d = 1'b1;
                else       pc_d   = pc_q + ADDR_W'(1);
`else
                pc_d = pc_q + ADDR_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) stack_q[sp_q[IdxW-1:0]] <= pc_q;
    end

    assign pc          = pc_q;
    assign sp          = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stk_err     = err_q;

endmodule
